// File: rtl/reg_fwd_scoreboard.sv
// Decode-stage operand forwarding, long-latency busy scoreboard and hazard stall; combinational
// forwarding/stall, busy updates one edge later. Optional stall counter behind FWD_STALL_CNT_EN.
// Backpressure: stall_ao holds decode; the scoreboard never self-clears.
package reg_fwd_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        rf_wr_en;
        logic        valid;
        logic        mem_read;
    } data_fwd_t;
endpackage

module reg_fwd_scoreboard
    import reg_fwd_pkg::*;
#(
    parameter int NUM_RS     = 2,
    parameter int NUM_STAGES = 2,
    parameter int NUM_REGS   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  data_fwd_t                stage_i [NUM_STAGES],
    input  logic [NUM_RS-1:0][4:0]   rs_i,
    input  logic [NUM_RS-1:0][31:0]  rs_data_i,
    input  logic [NUM_RS-1:0]        rs_used_i,
    input  logic                     issue_valid_i,
    input  logic                     issue_long_i,
    input  logic [4:0]               issue_rd_i,
    input  logic                     issue_wr_en_i,
    input  logic                     lw_done_i,
    input  logic [4:0]               lw_rd_i,
    input  logic [31:0]              lw_data_i,
    output logic [NUM_RS-1:0][31:0]  rs_data_ao,
    output logic                     load_use_hazard_ao,
    output logic                     stall_ao,
`ifdef FWD_STALL_CNT_EN
    output logic [15:0]              stall_cnt_o,
`endif
    output logic [NUM_REGS-1:0]      busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [31:0]         busy_ext;
    logic [NUM_RS-1:0]   raw_busy;
    logic [NUM_RS-1:0]   lw_hit;
    logic                waw_busy;
    logic                set_en;

    // Indices are 5 bits wide, so widen the scoreboard to 32 for safe lookup.
    assign busy_ext = 32'(busy_q);
    assign busy_o   = busy_q;

    always_comb begin
        load_use_hazard_ao = 1'b0;
        for (int p = 0; p < NUM_RS; p++) begin
            rs_data_ao[p] = rs_data_i[p];
            lw_hit[p]     = 1'b0;
            raw_busy[p]   = 1'b0;
            if (rs_used_i[p] && rs_i[p] != 5'd0) begin
                lw_hit[p]   = lw_done_i && (lw_rd_i == rs_i[p]);
                raw_busy[p] = busy_ext[rs_i[p]] && !lw_hit[p];
                if (lw_hit[p])
                    rs_data_ao[p] = lw_data_i;
                // Oldest first so the youngest matching stage overwrites last.
                for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                    if (stage_i[s].valid && stage_i[s].rf_wr_en && stage_i[s].rd == rs_i[p]) begin
                        rs_data_ao[p] = stage_i[s].rd_data;
                        if (s == 0 && stage_i[s].mem_read)
                            load_use_hazard_ao = 1'b1;
                    end
                end
            end
        end
    end

    assign waw_busy = issue_valid_i && issue_wr_en_i && (issue_rd_i != 5'd0) &&
                      busy_ext[issue_rd_i] && !(lw_done_i && lw_rd_i == issue_rd_i);

    assign stall_ao = issue_valid_i && (load_use_hazard_ao || (|raw_busy) || waw_busy);
    assign set_en   = issue_valid_i && !stall_ao && issue_long_i && issue_wr_en_i;

    // Set takes priority over clear: a reissue to the same rd owns the register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (set_en && issue_rd_i == 5'(r))
                    busy_q[r] <= 1'b1;
                else if (lw_done_i && lw_rd_i == 5'(r))
                    busy_q[r] <= 1'b0;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_cnt_o <= 16'd0;
        else if (stall_ao && stall_cnt_o != 16'hFFFF)
            stall_cnt_o <= stall_cnt_o + 16'd1;
    end
`endif

endmodule

// File: doc/reg_fwd_scoreboard.md
# reg_fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the decode stage. It serves `NUM_RS` source-register ports, forwarding from `NUM_STAGES` downstream pipeline stages, youngest first. It also holds a per-register busy scoreboard for multi-cycle (long-latency) writers such as the divider. From that it generates a single decode stall for load-use, RAW-on-busy and WAW-on-busy hazards, with an optional saturating stall counter for performance analysis.

## Interface
Parameters:
- `NUM_RS`, default 2: number of source-operand ports.
- `NUM_STAGES`, default 2: number of forwarding stages. Index 0 is the youngest (EX); `NUM_STAGES-1` is the oldest.
- `NUM_REGS`, default 32: architectural registers. Register 0 is hard-wired zero.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `stage_i`  in  `data_fwd_t`[NUM_STAGES]  per-stage `rd`, `rd_data`, `rf_wr_en`, `valid`, `mem_read`.
- `rs_i`  in  [NUM_RS][4:0]  source register indices.
- `rs_data_i`  in  [NUM_RS][31:0]  register-file read data.
- `rs_used_i`  in  [NUM_RS]  operand actually consumed.
- `issue_valid_i`  in  1  decode instruction attempts to advance this cycle.
- `issue_long_i`  in  1  issuing instruction has a long-latency writer.
- `issue_rd_i`  in  5  destination of the issuing instruction.
- `issue_wr_en_i`  in  1  issuing instruction writes `rd`.
- `lw_done_i`  in  1  long-latency unit writes back this cycle.
- `lw_rd_i`  in  5  long-latency writeback register.
- `lw_data_i`  in  32  long-latency writeback data.
- `rs_data_ao`  out  [NUM_RS][31:0]  forwarded operands (combinational).
- `load_use_hazard_ao`  out  1  any port hits a stage-0 load (combinational).
- `stall_ao`  out  1  decode must hold (combinational).
- `busy_o`  out  [NUM_REGS]  registered scoreboard.
- `stall_cnt_o`  out  16  stall cycles; present only with `FWD_STALL_CNT_EN`.

## Operation
- Match for port p at stage s: `stage_i[s].valid && rf_wr_en && rd == rs_i[p] && rs_used_i[p] && rs_i[p] != 0`.
- Operand priority, per port:
  - lowest stage index with a match;
  - then `lw_data_i` if `lw_done_i && lw_rd_i == rs_i[p]`, with `rs_i[p] != 0` and `rs_used_i[p]`;
  - then `rs_data_i[p]`.
- `rs_i == 0` always returns `rs_data_i` unmodified.
- Load-use: a stage-0 match with `stage_i[0].mem_read`. Matches in older stages never raise a load-use hazard.
- `raw_busy[p]`: `rs_used_i[p] && busy[rs_i[p]] && rs_i[p] != 0`, and not (`lw_done_i && lw_rd_i == rs_i[p]`).
- `waw_busy`: `issue_valid_i && issue_wr_en_i && issue_rd_i != 0 && busy[issue_rd_i]`, and not cleared this cycle by `lw_done_i`.
- `stall_ao` = `issue_valid_i && (load_use_hazard_ao || any raw_busy || waw_busy)`.
- Scoreboard update, per register r, on every clock:
  - **Set:** `issue_valid_i && !stall_ao && issue_long_i && issue_wr_en_i && issue_rd_i == r && r != 0`.
  - **Clear:** `lw_done_i && lw_rd_i == r`.
  - Set and clear of the same r in one cycle: set wins, so busy stays 1 and the new writer owns r.
- `busy[0]` is constant 0.
- `lw_done_i` for a register that is not busy is legal: the bit stays 0 and data is still bypassed.
- The scoreboard never self-clears. Flushing long ops is out of scope: issued long ops always write back.

## Timing
- Forwarding, `load_use_hazard_ao` and `stall_ao` are purely combinational, zero-cycle.
- `busy_o` updates at the rising edge after the issue or writeback cycle.
- A long op issued in cycle N:
  - a dependant in cycle N+1 sees busy=1 and stalls;
  - if `lw_done_i` for it arrives in cycle M, the dependant in cycle M gets `lw_data_i` with no stall;
  - from cycle M+1, busy=0.
- Reset (`rst_ni` low, asynchronous): `busy_o` = 0 and `stall_cnt_o` = 0 immediately.
  - Combinational outputs then follow the inputs with an empty scoreboard.
  - Reset asserted mid-operation drops all busy bits; any in-flight long-op writeback after reset is treated as not busy.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - a 16-bit counter increments each cycle `stall_ao` = 1;
  - it saturates at 16'hFFFF and resets to 0;
  - exposed on `stall_cnt_o`.
- Not defined: `stall_cnt_o` and the counter logic are absent. All other behaviour is identical.

## Test plan
- Priority: stage0 rd=5 data=0xA, stage1 rd=5 data=0xB, rs_i[0]=5 used → `rs_data_ao[0]`=0xA, no stall. Repeat with only stage1 matching → 0xB.
- x0 and unused operands: stage0 rd=0 data=0xFF and rs_i=0 → output equals `rs_data_i`. Any match with `rs_used_i`=0 → `rs_data_i`, no hazard.
- Load-use: stage0 `mem_read`=1 rd=7, rs_i[1]=7, issue_valid=1 → `load_use_hazard_ao`=1, `stall_ao`=1. Same load in stage1 → forwarded, no stall.
- Scoreboard: issue long rd=9 in cycle 0, then read rs=9 in cycles 1–3 → stall each cycle. `lw_done_i` rd=9 data=0x1234 in cycle 4 → operand 0x1234, no stall. `busy_o[9]`=0 in cycle 5.
- Simultaneous and WAW: busy[3]=1; issue long rd=3 → stall (WAW). With `lw_done_i` rd=3 in the same cycle → no stall, busy[3] remains 1.
- Counter and reset: with `FWD_STALL_CNT_EN`, 10 stall cycles → `stall_cnt_o`=10. Preload 16'hFFFF plus a stall → holds 16'hFFFF. Asserting `rst_ni` low asynchronously → counter and `busy_o` read 0 before the next edge.
